mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one byte-wide synchronous RAM port between instruction fetch (IF) and load/store (MEM).
- Each 1/2/4-byte access is sequenced as a series of byte cycles. Bytes are assembled little-endian into 32-bit words.
- Also acts as the pipeline stall controller: it merges its own busy status with the ID/EX stall requests into the 6-bit stall vector. That vector drives all inter-stage registers, including MEM/WB.

Parameters:
ADDR_W, 17, width of RAM byte address; request addresses are truncated to the low ADDR_W bits.

Ports:
clk  in  1  clock
rst  in  1  reset
if_req  in  1  fetch request; held high until if_done
if_addr  in  32  fetch byte address (always 4-byte access)
if_data  out  32  fetched instruction word
if_done  out  1  one-cycle pulse: if_data valid
mem_req  in  1  load/store request; held high until mem_done
mem_we  in  1  1=store, 0=load
mem_len  in  2  0=byte, 1=half, 2=word, 3=treated as word
mem_addr  in  32  load/store byte address
mem_wdata  in  32  store data; byte k = bits [8k+7:8k]
mem_rdata  out  32  load data, zero-extended above mem_len; the MEM stage sign-extends
mem_done  out  1  one-cycle pulse: access complete
id_stall_req  in  1  ID stall request (load-use hazard)
ex_stall_req  in  1  EX stall request (multi-cycle op)
ram_addr  out  ADDR_W  RAM byte address
ram_we  out  1  RAM write strobe
ram_dout  out  8  RAM write byte
ram_din  in  8  RAM read byte; valid the cycle after ram_addr is presented with ram_we=0
stall  out  6  [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB; 1=stop

Behaviour:
- Reset:
  - rst is synchronous and active-high; clk is the clock.
  - On reset, state goes to IDLE, counter=0, and all data and address registers are cleared.
  - Outputs after reset: if_done=0, mem_done=0, ram_we=0, ram_addr=0, ram_dout=0, if_data=0, mem_rdata=0.
  - Reset mid-access abandons the access: partial bytes are discarded and no done pulse is produced.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - mem_req has priority over if_req, because the MEM instruction is older.
  - On grant, the block latches requester, base address, byte count N, and write data; it clears the assembly register and sets cnt=0.
  - It then moves to WRITE if the grant is a store, otherwise to READ.
- READ:
  - Each cycle it drives ram_addr = base+cnt (mod 2^ADDR_W) and ram_we=0.
  - Byte k arrives on ram_din one cycle after its address and is stored into assembly bits [8k+7:8k].
  - The state persists for N+1 cycles: N address cycles plus one trailing capture cycle.
  - After the last byte is captured: load the output register (if_data or mem_rdata), assert the matching done for exactly 1 cycle, and go to DONE.
- WRITE:
  - Each cycle it drives ram_addr = base+cnt, ram_dout = byte cnt of the latched data, and ram_we=1.
  - After N cycles: ram_we=0, pulse mem_done, go to DONE.
- DONE:
  - Lasts one cycle with no grant, so a still-high request of the advancing pipeline is not reissued. Then returns to IDLE.
- Latency, from the grant cycle to the done pulse:
  - IF read: 6 cycles.
  - Word load: 6 cycles.
  - Byte load: 3 cycles.
  - Word store: 5 cycles.
  - Byte store: 2 cycles.
- Output registers hold their value until the next completion of the same requester.
- The request inputs are sampled only in IDLE. Changing address or data while busy has no effect.
- Stall vector is combinational, in priority order (first match wins):
  - mem_req && !mem_done -> 6'b011111
  - ex_stall_req -> 6'b001111
  - id_stall_req -> 6'b000111
  - if_req && !if_done -> 6'b000011
  - otherwise 6'b000000
  - WB is never stalled. An ID stall leaves EX running, which inserts a bubble into EX.
- Simultaneous events: with if_req and mem_req both high in IDLE, MEM is served first. IF waits and is served on the next IDLE; the pipeline is held by stall[1:0].

Test Plan:
- Reset, then idle -> all outputs 0, stall=000000; rst asserted during a READ at cnt=2 -> IDLE next cycle, no if_done, ram_we=0.
- if_req, if_addr=0x10, RAM[0x10..0x13]=13,00,A0,E3 -> ram_addr 0x10..0x13 on consecutive cycles; if_data=0xE3A00013 with if_done pulse 6 cycles after grant; stall=000011 until the done cycle.
- mem_req store, len=2, addr=0x100, wdata=0xDEADBEEF -> ram_we high 4 cycles with bytes EF,BE,AD,DE at 0x100..0x103; mem_done 5 cycles after grant; stall=011111 meanwhile.
- if_req and mem_req (load, len=0, addr=0x7, RAM[7]=0x80) in the same IDLE cycle -> MEM first, mem_rdata=0x00000080, then one DONE cycle, then the IF read starts.
- Half load at addr=0x1FFFF with ADDR_W=17 -> second byte read at ram_addr 0x00000 (wrap); both bytes assembled.
- ex_stall_req=1 alone -> stall=001111; with id_stall_req also 1 -> still 001111; mem_req pending plus ex_stall_req -> 011111.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one byte-wide synchronous RAM port shared by instruction
// fetch and load/store. Each access is split into byte cycles and assembled
// little-endian. The block also produces the pipeline stall vector.
module mem_port_arbiter #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_data,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  input  logic              id_stall_req,
  input  logic              ex_stall_req,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din,
  output logic [5:0]        stall
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, DONE = 2'd3} state_t;

  state_t            state_r, state_nxt_s;
  logic              req_mem_r, req_mem_nxt_s;
  logic [ADDR_W-1:0] base_r, base_nxt_s;
  logic [2:0]        n_r, n_nxt_s;
  logic [2:0]        cnt_r, cnt_nxt_s;
  logic [31:0]       wdata_r, wdata_nxt_s;
  logic [31:0]       asm_r, asm_nxt_s;
  logic [31:0]       if_data_r, if_data_nxt_s;
  logic [31:0]       mem_rdata_r, mem_rdata_nxt_s;
  logic              if_done_r, if_done_nxt_s;
  logic              mem_done_r, mem_done_nxt_s;
  logic [ADDR_W-1:0] ram_addr_r, ram_addr_nxt_s;
  logic              ram_we_r, ram_we_nxt_s;
  logic [7:0]        ram_dout_r, ram_dout_nxt_s;
  logic [1:0]        byte_sel_s;
  logic              unused_s;

  // Address bits above the RAM size are dropped by design.
  assign unused_s = ^{if_addr[31:ADDR_W], mem_addr[31:ADDR_W]};

  // Byte count of an access; length code 3 is handled as a full word.
  function automatic logic [2:0] len_to_n(input logic [1:0] len);
    case (len)
      2'd0:    len_to_n = 3'd1;
      2'd1:    len_to_n = 3'd2;
      default: len_to_n = 3'd4;
    endcase
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: MEM wins in IDLE; READ spans N+1 cycles, WRITE spans N.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (mem_req) begin
          state_nxt_s = mem_we ? WRITE : READ;
        end else if (if_req) begin
          state_nxt_s = READ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      READ: begin
        if (cnt_r == n_r) state_nxt_s = DONE;
        else              state_nxt_s = READ;
      end
      WRITE: begin
        if (cnt_r == (n_r - 3'd1)) state_nxt_s = DONE;
        else                       state_nxt_s = WRITE;
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output and datapath logic: grant latching, byte assembly, and the RAM
  // port values for the coming cycle so that every output is registered.
  always_comb begin
    req_mem_nxt_s   = req_mem_r;
    base_nxt_s      = base_r;
    n_nxt_s         = n_r;
    cnt_nxt_s       = cnt_r;
    wdata_nxt_s     = wdata_r;
    asm_nxt_s       = asm_r;
    if_data_nxt_s   = if_data_r;
    mem_rdata_nxt_s = mem_rdata_r;
    if_done_nxt_s   = 1'b0;
    mem_done_nxt_s  = 1'b0;
    byte_sel_s      = cnt_r[1:0] - 2'd1;
    case (state_r)
      IDLE: begin
        if (mem_req) begin
          req_mem_nxt_s = 1'b1;
          base_nxt_s    = mem_addr[ADDR_W-1:0];
          n_nxt_s       = len_to_n(mem_len);
          wdata_nxt_s   = mem_wdata;
          asm_nxt_s     = 32'd0;
          cnt_nxt_s     = 3'd0;
        end else if (if_req) begin
          req_mem_nxt_s = 1'b0;
          base_nxt_s    = if_addr[ADDR_W-1:0];
          n_nxt_s       = 3'd4;
          asm_nxt_s     = 32'd0;
          cnt_nxt_s     = 3'd0;
        end else begin
          cnt_nxt_s     = 3'd0;
        end
      end
      READ: begin
        // Byte cnt-1 returns now, one cycle behind its address.
        if (cnt_r != 3'd0) asm_nxt_s[{byte_sel_s, 3'b000} +: 8] = ram_din;
        else               asm_nxt_s = asm_r;
        if (cnt_r == n_r) begin
          if (req_mem_r) begin
            mem_rdata_nxt_s = asm_nxt_s;
            mem_done_nxt_s  = 1'b1;
          end else begin
            if_data_nxt_s   = asm_nxt_s;
            if_done_nxt_s   = 1'b1;
          end
        end else begin
          cnt_nxt_s = cnt_r + 3'd1;
        end
      end
      WRITE: begin
        if (cnt_r == (n_r - 3'd1)) mem_done_nxt_s = 1'b1;
        else                       cnt_nxt_s = cnt_r + 3'd1;
      end
      DONE:    cnt_nxt_s = cnt_r;
      default: cnt_nxt_s = 3'd0;
    endcase

    ram_addr_nxt_s = {ADDR_W{1'b0}};
    ram_we_nxt_s   = 1'b0;
    ram_dout_nxt_s = 8'd0;
    if ((state_nxt_s == READ) && (cnt_nxt_s < n_nxt_s)) begin
      ram_addr_nxt_s = base_nxt_s + ADDR_W'(cnt_nxt_s);
    end else if (state_nxt_s == WRITE) begin
      ram_addr_nxt_s = base_nxt_s + ADDR_W'(cnt_nxt_s);
      ram_we_nxt_s   = 1'b1;
      ram_dout_nxt_s = wdata_nxt_s[{cnt_nxt_s[1:0], 3'b000} +: 8];
    end else begin
      ram_addr_nxt_s = {ADDR_W{1'b0}};
    end
  end

  // Datapath and output registers; reset drops any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_mem_r   <= 1'b0;
      base_r      <= {ADDR_W{1'b0}};
      n_r         <= 3'd0;
      cnt_r       <= 3'd0;
      wdata_r     <= 32'd0;
      asm_r       <= 32'd0;
      if_data_r   <= 32'd0;
      mem_rdata_r <= 32'd0;
      if_done_r   <= 1'b0;
      mem_done_r  <= 1'b0;
      ram_addr_r  <= {ADDR_W{1'b0}};
      ram_we_r    <= 1'b0;
      ram_dout_r  <= 8'd0;
    end else begin
      req_mem_r   <= req_mem_nxt_s;
      base_r      <= base_nxt_s;
      n_r         <= n_nxt_s;
      cnt_r       <= cnt_nxt_s;
      wdata_r     <= wdata_nxt_s;
      asm_r       <= asm_nxt_s;
      if_data_r   <= if_data_nxt_s;
      mem_rdata_r <= mem_rdata_nxt_s;
      if_done_r   <= if_done_nxt_s;
      mem_done_r  <= mem_done_nxt_s;
      ram_addr_r  <= ram_addr_nxt_s;
      ram_we_r    <= ram_we_nxt_s;
      ram_dout_r  <= ram_dout_nxt_s;
    end
  end

  // Stall vector: oldest hazard first; WB always advances.
  always_comb begin
    stall = 6'b000000;
    if (mem_req && !mem_done_r)    stall = 6'b011111;
    else if (ex_stall_req)         stall = 6'b001111;
    else if (id_stall_req)         stall = 6'b000111;
    else if (if_req && !if_done_r) stall = 6'b000011;
    else                           stall = 6'b000000;
  end

  assign if_data   = if_data_r;
  assign if_done   = if_done_r;
  assign mem_rdata = mem_rdata_r;
  assign mem_done  = mem_done_r;
  assign ram_addr  = ram_addr_r;
  assign ram_we    = ram_we_r;
  assign ram_dout  = ram_dout_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter with a byte-wide synchronous RAM model.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 17;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [31:0]       if_addr;
  logic [31:0]       if_data;
  logic              if_done;
  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_len;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_done;
  logic              id_stall_req;
  logic              ex_stall_req;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din;
  logic [5:0]        stall;

  logic              pl_en;
  logic [ADDR_W-1:0] pl_addr;
  logic [7:0]        pl_data;
  logic [7:0]        ram [0:(1<<ADDR_W)-1];

  typedef struct { logic [31:0] data; int cyc; } rd_exp_t;
  typedef struct { logic [ADDR_W-1:0] addr; logic [7:0] data; int cyc; } wr_exp_t;
  rd_exp_t if_q[$];
  rd_exp_t mem_q[$];
  wr_exp_t wr_q[$];

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int p;

  mem_port_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .id_stall_req(id_stall_req), .ex_stall_req(ex_stall_req),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_dout(ram_dout), .ram_din(ram_din),
    .stall(stall)
  );

  always #5 clk = ~clk;

  // Cycle counter.
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM: read data appears the cycle after the address.
  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (ram_we) ram[ram_addr] <= ram_dout;
    ram_din <= ram[ram_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic wait_done(input logic sel_mem);
    int n;
    n = 0;
    while (((sel_mem ? mem_done : if_done) !== 1'b1) && (n < 40)) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 40) begin
      failures++;
      $display("FAIL done_timeout sel_mem=%0d waited=%0d required=<40", sel_mem, n);
    end
  endtask

  task automatic monitor();
    rd_exp_t e;
    wr_exp_t w;
    forever begin
      @(negedge clk);
      if (if_done === 1'b1) begin
        if (if_q.size() == 0) chk("if_done_unexpected", 32'(if_done), 32'd0);
        else begin
          e = if_q.pop_front();
          chk("if_data", if_data, e.data);
          chk("if_done_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (mem_done === 1'b1) begin
        if (mem_q.size() == 0) chk("mem_done_unexpected", 32'(mem_done), 32'd0);
        else begin
          e = mem_q.pop_front();
          chk("mem_rdata", mem_rdata, e.data);
          chk("mem_done_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (ram_we === 1'b1) begin
        if (wr_q.size() == 0) chk("ram_we_unexpected", 32'(ram_we), 32'd0);
        else begin
          w = wr_q.pop_front();
          chk("wr_addr", 32'(ram_addr), 32'(w.addr));
          chk("wr_data", 32'(ram_dout), 32'(w.data));
          chk("wr_cycle", 32'(cyc), 32'(w.cyc));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = 32'd0; mem_req = 1'b0; mem_we = 1'b0;
    mem_len = 2'd0; mem_addr = 32'd0; mem_wdata = 32'd0;
    id_stall_req = 1'b0; ex_stall_req = 1'b0;
    pl_en = 1'b0; pl_addr = '0; pl_data = 8'd0;
    fork monitor(); join_none
    tick();
    preload(17'h10, 8'h13); preload(17'h11, 8'h00); preload(17'h12, 8'hA0); preload(17'h13, 8'hE3);
    preload(17'h20, 8'h11); preload(17'h21, 8'h22); preload(17'h22, 8'h33); preload(17'h23, 8'h44);
    preload(17'h07, 8'h80); preload(17'h1FFFF, 8'h5A); preload(17'h00000, 8'hC3);
    tick();
    rst = 1'b0;
    tick();

    // Idle after reset
    chk("rst_if_done", 32'(if_done), 32'd0);
    chk("rst_mem_done", 32'(mem_done), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_dout", 32'(ram_dout), 32'd0);
    chk("rst_if_data", if_data, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    chk("rst_stall", 32'(stall), 32'h00);

    // Instruction fetch of a word at 0x10
    p = cyc; if_addr = 32'h10; if_req = 1'b1;
    if_q.push_back('{data: 32'hE3A00013, cyc: p + 6});
    #1 chk("if_stall_grant", 32'(stall), 32'h03);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("if_ram_addr", 32'(ram_addr), 32'h10 + 32'(i));
      chk("if_ram_we", 32'(ram_we), 32'd0);
      chk("if_stall", 32'(stall), 32'h03);
    end
    wait_done(1'b0);
    chk("if_stall_done", 32'(stall), 32'h00);
    if_req = 1'b0;
    tick();

    // Word store; later changes to address and data must be ignored
    p = cyc; mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd2;
    mem_addr = 32'h100; mem_wdata = 32'hDEADBEEF;
    wr_q.push_back('{addr: 17'h100, data: 8'hEF, cyc: p + 1});
    wr_q.push_back('{addr: 17'h101, data: 8'hBE, cyc: p + 2});
    wr_q.push_back('{addr: 17'h102, data: 8'hAD, cyc: p + 3});
    wr_q.push_back('{addr: 17'h103, data: 8'hDE, cyc: p + 4});
    mem_q.push_back('{data: 32'h0, cyc: p + 5});
    #1 chk("st_stall_grant", 32'(stall), 32'h1F);
    tick();
    mem_addr = 32'h200; mem_wdata = 32'h0;
    #1 chk("st_stall_busy", 32'(stall), 32'h1F);
    wait_done(1'b1);
    chk("st_stall_done", 32'(stall), 32'h00);
    mem_req = 1'b0;
    tick();

    // IF and MEM together: byte load wins, then DONE, then the fetch
    p = cyc; mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd0; mem_addr = 32'h7;
    if_req = 1'b1; if_addr = 32'h20;
    mem_q.push_back('{data: 32'h00000080, cyc: p + 3});
    if_q.push_back('{data: 32'h44332211, cyc: p + 10});
    #1 chk("arb_stall_both", 32'(stall), 32'h1F);
    wait_done(1'b1);
    mem_req = 1'b0;
    #1 chk("arb_stall_if_waits", 32'(stall), 32'h03);
    tick();
    chk("arb_idle_ram_addr", 32'(ram_addr), 32'h0);
    tick();
    chk("arb_if_first_addr", 32'(ram_addr), 32'h20);
    wait_done(1'b0);
    if_req = 1'b0;
    tick();

    // Half load wrapping past the top of the RAM
    p = cyc; mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd1; mem_addr = 32'h8001FFFF;
    mem_q.push_back('{data: 32'h0000C35A, cyc: p + 4});
    tick();
    chk("wrap_addr0", 32'(ram_addr), 32'h1FFFF);
    tick();
    chk("wrap_addr1", 32'(ram_addr), 32'h00000);
    wait_done(1'b1);
    mem_req = 1'b0;
    tick();

    // Byte store; mem_rdata keeps the previous load result
    p = cyc; mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd0;
    mem_addr = 32'h300; mem_wdata = 32'h123456A7;
    wr_q.push_back('{addr: 17'h300, data: 8'hA7, cyc: p + 1});
    mem_q.push_back('{data: 32'h0000C35A, cyc: p + 2});
    wait_done(1'b1);
    mem_req = 1'b0;
    tick();

    // Length code 3 reads back the stored word
    p = cyc; mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd3; mem_addr = 32'h100;
    mem_q.push_back('{data: 32'hDEADBEEF, cyc: p + 6});
    wait_done(1'b1);
    mem_req = 1'b0;
    tick();

    // Stall priority
    ex_stall_req = 1'b1;
    #1 chk("stall_ex", 32'(stall), 32'h0F);
    id_stall_req = 1'b1;
    #1 chk("stall_ex_id", 32'(stall), 32'h0F);
    ex_stall_req = 1'b0;
    #1 chk("stall_id", 32'(stall), 32'h07);
    id_stall_req = 1'b0;
    #1 chk("stall_none", 32'(stall), 32'h00);
    tick();
    p = cyc; ex_stall_req = 1'b1; mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd0; mem_addr = 32'h7;
    mem_q.push_back('{data: 32'h00000080, cyc: p + 3});
    #1 chk("stall_mem_ex", 32'(stall), 32'h1F);
    wait_done(1'b1);
    chk("stall_ex_at_done", 32'(stall), 32'h0F);
    mem_req = 1'b0; ex_stall_req = 1'b0;
    tick();

    // Reset in the middle of a fetch, at cnt=2
    p = cyc; if_addr = 32'h10; if_req = 1'b1;
    tick(); tick(); tick();
    chk("rstmid_addr_cnt2", 32'(ram_addr), 32'h12);
    rst = 1'b1; if_req = 1'b0;
    tick();
    rst = 1'b0;
    chk("rstmid_if_done", 32'(if_done), 32'd0);
    chk("rstmid_ram_we", 32'(ram_we), 32'd0);
    chk("rstmid_ram_addr", 32'(ram_addr), 32'd0);
    chk("rstmid_if_data", if_data, 32'd0);
    chk("rstmid_mem_rdata", mem_rdata, 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rstmid_no_done", 32'(if_done), 32'd0);
    end

    chk("if_q_drained", 32'(if_q.size()), 32'd0);
    chk("mem_q_drained", 32'(mem_q.size()), 32'd0);
    chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
